// File: rtl/led_counter_ctrl.sv
// LED/trigger counter with run enable, prescaler, direction, synchronous load and
// wrap/modulo/saturate/ping-pong modes; drives a registered terminal-count pulse and an LED tap.
module led_counter_ctrl #(
    parameter int CNT_W      = 32,
    parameter int LED_N      = 4,
    parameter int TAP_LSB    = 28,
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk1,
    input  logic                  rstn,
    input  logic                  en,
    input  logic                  dir,
    input  logic [1:0]            mode,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [CNT_W-1:0]      term_val,
    input  logic                  load,
    input  logic [CNT_W-1:0]      load_val,
    output logic [CNT_W-1:0]      cnt,
    output logic [LED_N-1:0]      led,
    output logic                  tc
);

    localparam logic [1:0] MODE_WRAP = 2'b00;
    localparam logic [1:0] MODE_MOD  = 2'b01;
    localparam logic [1:0] MODE_SAT  = 2'b10;
    localparam logic [1:0] MODE_PP   = 2'b11;

    logic [PRESCALE_W-1:0] pre_q, pre_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  tc_q, tc_d;
    logic                  pp_up_q, pp_up_d;

    logic                  tick;
    logic [CNT_W-1:0]      cnt_inc, cnt_dec, step_cnt;
    logic                  step_tc, step_pp_up;
    logic                  at_zero, at_top;

    assign tick    = en && (pre_q == prescale);
    assign cnt_inc = cnt_q + 1'b1;
    assign cnt_dec = cnt_q - 1'b1;
    assign at_zero = (cnt_q == '0);
    assign at_top  = (cnt_q >= term_val);

    // Candidate value for a tick; only committed when tick wins over load.
    always_comb begin
        step_cnt   = cnt_q;
        step_tc    = 1'b0;
        step_pp_up = pp_up_q;
        case (mode)
            MODE_WRAP: begin
                step_cnt = dir ? cnt_inc : cnt_dec;
                step_tc  = dir ? (cnt_q == {CNT_W{1'b1}}) : at_zero;
            end
            MODE_MOD: begin
                if (dir) begin
                    step_cnt = at_top ? '0 : cnt_inc;
                    step_tc  = at_top;
                end else begin
                    step_cnt = at_zero ? term_val : cnt_dec;
                    step_tc  = at_zero;
                end
            end
            MODE_SAT: begin
                if (dir) begin
                    step_cnt = at_top ? term_val : cnt_inc;
                    step_tc  = !at_top && (cnt_inc == term_val);
                end else begin
                    step_cnt = at_zero ? cnt_q : cnt_dec;
                    step_tc  = (cnt_q == CNT_W'(1));
                end
            end
            default: begin
                if (pp_up_q) begin
                    if (at_top) begin
                        step_cnt   = (term_val == '0) ? '0 : term_val - 1'b1;
                        step_tc    = 1'b1;
                        step_pp_up = 1'b0;
                    end else begin
                        step_cnt = cnt_inc;
                    end
                end else begin
                    if (at_zero) begin
                        step_cnt   = (term_val == '0) ? '0 : CNT_W'(1);
                        step_tc    = 1'b1;
                        step_pp_up = 1'b1;
                    end else begin
                        step_cnt = cnt_dec;
                    end
                end
            end
        endcase
    end

    always_comb begin
        pre_d   = pre_q;
        cnt_d   = cnt_q;
        tc_d    = 1'b0;
        pp_up_d = pp_up_q;
        if (load) begin
            cnt_d   = load_val;
            pre_d   = '0;
            pp_up_d = dir;
        end else if (tick) begin
            pre_d   = '0;
            cnt_d   = step_cnt;
            tc_d    = step_tc;
            pp_up_d = step_pp_up;
        end else if (en) begin
            pre_d = pre_q + 1'b1;
        end
    end

    always_ff @(posedge clk1 or negedge rstn) begin
        if (!rstn) begin
            pre_q   <= '0;
            cnt_q   <= '0;
            tc_q    <= 1'b0;
            pp_up_q <= 1'b1;
        end else begin
            pre_q   <= pre_d;
            cnt_q   <= cnt_d;
            tc_q    <= tc_d;
            pp_up_q <= pp_up_d;
        end
    end

    assign cnt = cnt_q;
    assign led = cnt_q[TAP_LSB +: LED_N];
    assign tc  = tc_q;

endmodule

// File: tb/tb_led_counter_ctrl.sv
// Directed bench for led_counter_ctrl: hand-computed count/tc/led sequences per mode.
module tb_led_counter_ctrl;

    logic        clk1 = 1'b0;
    logic        rstn;
    logic        en;
    logic        dir;
    logic [1:0]  mode;
    logic [7:0]  prescale;
    logic [31:0] term_val;
    logic        load;
    logic [31:0] load_val;
    logic [31:0] cnt;
    logic [3:0]  led;
    logic        tc;

    int n_chk = 0;
    int n_bad = 0;

    led_counter_ctrl dut (
        .clk1     (clk1),
        .rstn     (rstn),
        .en       (en),
        .dir      (dir),
        .mode     (mode),
        .prescale (prescale),
        .term_val (term_val),
        .load     (load),
        .load_val (load_val),
        .cnt      (cnt),
        .led      (led),
        .tc       (tc)
    );

    always #5 clk1 = ~clk1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // One active edge, then settle on the falling edge where outputs are sampled.
    task automatic clk_n(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk1);
            @(negedge clk1);
        end
    endtask

    task automatic do_load(input logic [31:0] v);
        load     = 1'b1;
        load_val = v;
        clk_n(1);
        load     = 1'b0;
    endtask

    initial begin
        int sat_exp[5];
        int sat_tc[5];
        int pp_exp[7];
        int pp_tc[7];
        sat_exp = '{1, 2, 3, 3, 3};
        sat_tc  = '{0, 0, 1, 0, 0};
        pp_exp  = '{1, 2, 3, 2, 1, 0, 1};
        pp_tc   = '{0, 0, 0, 1, 0, 0, 1};

        rstn = 1'b0; en = 1'b1; dir = 1'b1; mode = 2'b00; prescale = 8'd0;
        term_val = 32'd0; load = 1'b0; load_val = 32'd0;

        // reset
        #2;
        chk("rst_cnt", cnt, 32'd0);
        chk("rst_led", {28'd0, led}, 32'd0);
        chk("rst_tc", {31'd0, tc}, 32'd0);
        @(negedge clk1);
        rstn = 1'b1;
        clk_n(1);
        chk("rel_cnt1", cnt, 32'd1);
        clk_n(2);
        chk("run_cnt3", cnt, 32'd3);
        #2 rstn = 1'b0;
        #1;
        chk("async_rst_cnt", cnt, 32'd0);
        @(negedge clk1);
        rstn = 1'b1;
        clk_n(1);
        chk("rerel_cnt1", cnt, 32'd1);

        // wrap up across all-ones
        do_load(32'hFFFF_FFFE);
        chk("wrap_ld", cnt, 32'hFFFF_FFFE);
        clk_n(1);
        chk("wrap_max", cnt, 32'hFFFF_FFFF);
        chk("wrap_max_led", {28'd0, led}, 32'hF);
        chk("wrap_max_tc", {31'd0, tc}, 32'd0);
        clk_n(1);
        chk("wrap_0", cnt, 32'd0);
        chk("wrap_0_tc", {31'd0, tc}, 32'd1);
        chk("wrap_0_led", {28'd0, led}, 32'd0);
        clk_n(1);
        chk("wrap_1_tc", {31'd0, tc}, 32'd0);

        // wrap down across zero
        dir = 1'b0;
        do_load(32'd0);
        clk_n(1);
        chk("wrapdn_cnt", cnt, 32'hFFFF_FFFF);
        chk("wrapdn_tc", {31'd0, tc}, 32'd1);
        dir = 1'b1;

        // prescale 3 with enable freeze
        prescale = 8'd3;
        do_load(32'd0);
        clk_n(3);
        chk("pre_hold", cnt, 32'd0);
        clk_n(1);
        chk("pre_step", cnt, 32'd1);
        clk_n(2);
        en = 1'b0;
        clk_n(5);
        chk("frz_cnt", cnt, 32'd1);
        en = 1'b1;
        clk_n(1);
        chk("resume_hold", cnt, 32'd1);
        clk_n(1);
        chk("resume_step", cnt, 32'd2);
        clk_n(3);
        chk("resume_hold2", cnt, 32'd2);
        clk_n(1);
        chk("resume_step2", cnt, 32'd3);

        // modulo 9
        prescale = 8'd0; mode = 2'b01; term_val = 32'd9;
        do_load(32'd0);
        for (int i = 1; i <= 9; i++) begin
            clk_n(1);
            chk("mod_up", cnt, 32'(i));
            chk("mod_up_tc", {31'd0, tc}, 32'd0);
        end
        clk_n(1);
        chk("mod_wrap", cnt, 32'd0);
        chk("mod_wrap_tc", {31'd0, tc}, 32'd1);
        dir = 1'b0;
        do_load(32'd2);
        clk_n(2);
        chk("mod_dn0", cnt, 32'd0);
        chk("mod_dn0_tc", {31'd0, tc}, 32'd0);
        clk_n(1);
        chk("mod_dn9", cnt, 32'd9);
        chk("mod_dn9_tc", {31'd0, tc}, 32'd1);
        dir = 1'b1;
        do_load(32'd12);
        clk_n(1);
        chk("mod_over", cnt, 32'd0);
        chk("mod_over_tc", {31'd0, tc}, 32'd1);
        term_val = 32'd0;
        clk_n(1);
        chk("mod_t0_cnt", cnt, 32'd0);
        chk("mod_t0_tc", {31'd0, tc}, 32'd1);

        // saturate 3
        mode = 2'b10; term_val = 32'd3;
        do_load(32'd0);
        for (int i = 0; i < 5; i++) begin
            clk_n(1);
            chk("sat_cnt", cnt, 32'(sat_exp[i]));
            chk("sat_tc", {31'd0, tc}, 32'(sat_tc[i]));
        end

        // ping-pong 3
        mode = 2'b11;
        do_load(32'd0);
        for (int i = 0; i < 7; i++) begin
            clk_n(1);
            chk("pp_cnt", cnt, 32'(pp_exp[i]));
            chk("pp_tc", {31'd0, tc}, 32'(pp_tc[i]));
        end

        // load colliding with a tick
        mode = 2'b00; prescale = 8'd3;
        do_load(32'd0);
        clk_n(3);
        load = 1'b1; load_val = 32'd5;
        clk_n(1);
        load = 1'b0;
        chk("coll_cnt", cnt, 32'd5);
        chk("coll_tc", {31'd0, tc}, 32'd0);
        clk_n(3);
        chk("coll_pre_rst", cnt, 32'd5);
        clk_n(1);
        chk("coll_next", cnt, 32'd6);

        // mode change mid-run
        prescale = 8'd0;
        do_load(32'd20);
        mode = 2'b01; term_val = 32'd9;
        clk_n(1);
        chk("modechg_cnt", cnt, 32'd0);
        chk("modechg_tc", {31'd0, tc}, 32'd1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
